// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 16-way mux round-robin arbiter.
// Imported by rr_pick and mux16_rr_arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {IDLE, BUSY} arb_state_t;
   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [N_REQ-1:0] req_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate req by ptr, find first set bit, un-rotate.
// Purely combinational; idx is meaningless when any is low.
module rr_pick
   import mux_arb_pkg::*;
(
   input  req_t req,
   input  sel_t ptr,
   output logic any,
   output sel_t idx
);

   req_t rot;
   sel_t off;

   always_comb begin
      rot = req_t'({req, req} >> ptr);
      off = '0;
      // Descending scan leaves the lowest set bit of rot in off
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = sel_t'(i);
      end
      any = |req;
      idx = off + ptr;
   end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner arbitration for a shared 16:1 mux select.
// Optional forced release after MAX_HOLD cycles: MUX16_ARB_TIMEOUT_EN.
module mux16_rr_arbiter
   import mux_arb_pkg::*;
`ifdef MUX16_ARB_TIMEOUT_EN
#(
   parameter int unsigned MAX_HOLD = 64
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  req_t req,
   input  logic rel,
   output sel_t select,
   output req_t grant,
   output logic valid,
   output logic timeout
);

   arb_state_t state_q, state_d;
   sel_t ptr_q, ptr_d;
   sel_t sel_q, sel_d;
   req_t grant_q, grant_d;
   logic valid_q, valid_d;
   logic pick_any;
   sel_t pick_idx;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

`ifdef MUX16_ARB_TIMEOUT_EN
   logic [15:0] cnt_q;
   logic hold_max;
   logic force_d;
   logic to_q;

   assign hold_max = (cnt_q == 16'(MAX_HOLD - 1));

   // Count resets while idle so the first BUSY cycle sees zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         to_q  <= force_d;
         cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 16'd1;
      end
   end

   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      valid_d = valid_q;
`ifdef MUX16_ARB_TIMEOUT_EN
      force_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d           = BUSY;
               sel_d             = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               valid_d           = 1'b1;
               ptr_d             = pick_idx + sel_t'(1);
            end
         end
         BUSY: begin
            if (rel || !req[sel_q]) begin
               state_d = IDLE;
               grant_d = '0;
               valid_d = 1'b0;
            end
`ifdef MUX16_ARB_TIMEOUT_EN
            else if (hold_max) begin
               state_d = IDLE;
               grant_d = '0;
               valid_d = 1'b0;
               force_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
      end
   end

   assign select = sel_q;
   assign grant  = grant_q;
   assign valid  = valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter driving a 16:1 data mux.
// Reference model recomputes ownership from the round-robin rules.
module tb_mux16_rr_arbiter;

`ifdef MUX16_ARB_TIMEOUT_EN
   localparam int MH = 8;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [15:0] req = '0;
   logic rel = 1'b0;
   logic [3:0] select;
   logic [15:0] grant;
   logic valid;
   logic timeout;
   logic [15:0] data = '0;
   logic mux_out;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

`ifdef MUX16_ARB_TIMEOUT_EN
   mux16_rr_arbiter #(.MAX_HOLD(MH)) dut (
`else
   mux16_rr_arbiter dut (
`endif
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .rel     (rel),
      .select  (select),
      .grant   (grant),
      .valid   (valid),
      .timeout (timeout)
   );

   assign mux_out = data[select];

   typedef struct {
      logic [15:0] g;
      logic [3:0]  s;
      logic        v;
      logic        t;
   } exp_t;

   exp_t q[$];
   exp_t pe;
   exp_t me;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Model: owner index or idle, priority pointer, hold count
   bit m_busy;
   int m_own, m_ptr, m_sel, m_cnt, w;
   bit m_to;

   function automatic int find_winner(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++)
         if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 0; m_own = 0; m_ptr = 0;
         m_sel = 0; m_cnt = 0; m_to = 0;
         q.delete();
      end else begin
         m_to = 0;
         if (!m_busy) begin
            w = find_winner(req, m_ptr);
            if (w >= 0) begin
               m_busy = 1; m_own = w; m_sel = w;
               m_ptr = (w + 1) % 16; m_cnt = 0;
            end
         end
         else if (rel || !req[m_own]) m_busy = 0;
`ifdef MUX16_ARB_TIMEOUT_EN
         else if (m_cnt == MH - 1) begin
            m_busy = 0; m_to = 1;
         end
`endif
         else m_cnt++;
         pe.g = m_busy ? (16'd1 << m_own) : 16'd0;
         pe.s = 4'(m_sel);
         pe.v = m_busy;
         pe.t = m_to;
         q.push_back(pe);
      end
   end

   always @(negedge clk) begin
      if (reset_n && q.size() > 0) begin
         me = q.pop_front();
         chk("sb_grant", grant, me.g);
         chk("sb_select", select, me.s);
         chk("sb_valid", valid, me.v);
         chk("sb_timeout", timeout, me.t);
         chk("sb_mux", mux_out, data[me.s]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      data = 16'($urandom);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_valid", valid, 0);
      chk("rst_select", select, 0);
      chk("rst_timeout", timeout, 0);
      tick(); tick();
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_valid", valid, 0);
         chk("idle_grant", grant, 0);
         chk("idle_select", select, 0);
      end

      req = 16'h0010;
      tick();
      chk("g4_grant", grant, 16'h0010);
      chk("g4_select", select, 4);
      chk("g4_valid", valid, 1);
      tick(); tick(); tick();
      rel = 1'b1; req = '0;
      tick();
      chk("g4_rel_grant", grant, 0);
      chk("g4_rel_valid", valid, 0);
      rel = 1'b0;

      req = 16'hFFFF;
      tick();
      chk("pre_rst_sel", select, 5);
      #2 reset_n = 1'b0;
      #1;
      chk("async_grant", grant, 0);
      chk("async_valid", valid, 0);
      chk("async_select", select, 0);
      tick();
      reset_n = 1'b1;
      rel = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         chk("rr_select", select, i % 16);
         chk("rr_valid", valid, 1);
         tick();
         chk("rr_bubble", valid, 0);
      end
      rel = 1'b0; req = '0;
      tick();

      req = 16'h4000; tick();
      req = '0; tick();
      req = 16'h0009; tick();
      chk("wrap_sel0", select, 0);
      chk("wrap_grant0", grant, 16'h0001);
      req = '0; tick();
      req = 16'h0009; tick();
      chk("wrap_sel3", select, 3);
      chk("wrap_grant3", grant, 16'h0008);
      req = '0; tick();

      req = 16'h0020; tick();
      chk("drop_sel5", select, 5);
      req = 16'h0200; tick();
      chk("drop_exit", valid, 0);
      tick();
      chk("drop_grant9", grant, 16'h0200);
      chk("drop_sel9", select, 9);
      req = '0; tick();

      req = 16'h0004; tick();
      chk("hold_sel2", select, 2);
`ifdef MUX16_ARB_TIMEOUT_EN
      repeat (7) tick();
      chk("to_hold8", valid, 1);
      chk("to_pre", timeout, 0);
      tick();
      chk("to_valid", valid, 0);
      chk("to_pulse", timeout, 1);
      tick();
      chk("to_once", timeout, 0);
      repeat (7) tick();
      rel = 1'b1;
      tick();
      chk("to_rel_valid", valid, 0);
      chk("to_rel_nopulse", timeout, 0);
      rel = 1'b0;
`else
      repeat (100) tick();
      chk("hold_forever", valid, 1);
      chk("hold_no_to", timeout, 0);
`endif
      req = '0; tick();

      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: req = 16'($urandom);
               1: req = 16'd1 << $urandom_range(0, 15);
               2: req = 16'hFFFF;
               default: req = '0;
            endcase
         end
         rel = ($urandom_range(0, 5) == 0);
         tick();
      end

      req = '0; rel = 1'b0;
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
